// File: rtl/bouncing_box_renderer_pkg.sv
// Shared definitions for the bouncing box pixel source: active-area size,
// 24-bit colour constants and the box state encoding.
package bouncing_box_renderer_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam logic [23:0] BG_COLOR     = 24'h000040;
  localparam logic [23:0] BOX_COLOR    = 24'hFF8000;
  localparam logic [23:0] FLASH_COLOR  = 24'hFFFFFF;
  localparam logic [23:0] BORDER_COLOR = 24'h00FF00;

  typedef enum logic {
    RUN   = 1'b0,
    FLASH = 1'b1
  } state_t;

endpackage

// File: rtl/bouncing_box_renderer_axis_bouncer.sv
// One axis of box motion: position and direction, clamped to [0, LIMIT-BOX_SIZE].
// bounce_o reports whether the next step would hit an edge; the parent
// qualifies it with its own step enable.
module axis_bouncer
  import bouncing_box_renderer_pkg::*;
#(
  parameter int LIMIT    = H_ACTIVE,
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 2,
  parameter int INIT     = 0
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        step_i,
  output logic [10:0] pos_o,
  output logic        bounce_o
);

  localparam logic [10:0] LIM_W  = 11'(LIMIT);
  localparam logic [10:0] SIZE_W = 11'(BOX_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] INIT_W = 11'(INIT);

  logic [10:0] pos_q, pos_d;
  logic        dir_q, dir_d;  // 1 = moving towards LIMIT

  // Next position and direction for one step, with edge clamping.
  always_comb begin
    pos_d    = pos_q;
    dir_d    = dir_q;
    bounce_o = 1'b0;
    if (dir_q) begin
      if (pos_q + SIZE_W + STEP_W > LIM_W) begin
        pos_d    = LIM_W - SIZE_W;
        dir_d    = 1'b0;
        bounce_o = 1'b1;
      end else begin
        pos_d = pos_q + STEP_W;
      end
    end else begin
      if (pos_q < STEP_W) begin
        pos_d    = '0;
        dir_d    = 1'b1;
        bounce_o = 1'b1;
      end else begin
        pos_d = pos_q - STEP_W;
      end
    end
  end

  // Commit the step only on an enabled frame tick.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pos_q <= INIT_W;
      dir_q <= 1'b1;
    end else if (step_i) begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/bouncing_box_renderer.sv
// Bouncing box pixel source for the VGA timing block. Returns the colour of
// the pixel at next_x/next_y one CLOCK_50 cycle later. The box moves once per
// frame (at the start of vertical blank) and flashes white after each bounce.
// Optional build macro BORDER_EN adds a one-pixel green frame around the
// active area.
module bouncing_box_renderer
  import bouncing_box_renderer_pkg::*;
#(
  parameter int BOX_SIZE     = 32,
  parameter int STEP         = 2,
  parameter int FLASH_FRAMES = 8,
  parameter int INIT_X       = 100,
  parameter int INIT_Y       = 60
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  input  logic       pause,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       frame_tick,
  output logic       hit
);

  localparam logic [9:0]  H_LIM        = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LIM        = 10'(V_ACTIVE);
  localparam logic [10:0] SIZE_W       = 11'(BOX_SIZE);
  localparam logic [7:0]  FLASH_RELOAD = 8'(FLASH_FRAMES - 1);

  logic        vb_q;
  logic        frame_tick_q, hit_q;
  state_t      state_q;
  logic [7:0]  flash_cnt_q;
  logic [23:0] rgb_q, rgb_d;
  logic [10:0] box_x, box_y;
  logic        bounce_x, bounce_y;
  logic        tick_w, step_w, bounce_w;

  // Rising edge of "row 480 is being scanned" marks the start of vertical blank.
  assign tick_w   = (next_y == V_LIM) && !vb_q;
  assign step_w   = tick_w && !pause;
  assign bounce_w = step_w && (bounce_x || bounce_y);

  axis_bouncer #(
    .LIMIT   (H_ACTIVE),
    .BOX_SIZE(BOX_SIZE),
    .STEP    (STEP),
    .INIT    (INIT_X)
  ) u_axis_x (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .step_i  (step_w),
    .pos_o   (box_x),
    .bounce_o(bounce_x)
  );

  axis_bouncer #(
    .LIMIT   (V_ACTIVE),
    .BOX_SIZE(BOX_SIZE),
    .STEP    (STEP),
    .INIT    (INIT_Y)
  ) u_axis_y (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .step_i  (step_w),
    .pos_o   (box_y),
    .bounce_o(bounce_y)
  );

  // Frame tick / hit pulses and the RUN/FLASH state with its frame counter.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      vb_q         <= 1'b0;
      frame_tick_q <= 1'b0;
      hit_q        <= 1'b0;
      state_q      <= RUN;
      flash_cnt_q  <= '0;
    end else begin
      vb_q         <= (next_y == V_LIM);
      frame_tick_q <= tick_w;
      hit_q        <= bounce_w;
      if (step_w) begin
        case (state_q)
          RUN: begin
            if (bounce_w) begin
              state_q     <= FLASH;
              flash_cnt_q <= FLASH_RELOAD;
            end
          end
          FLASH: begin
            if (bounce_w) begin
              flash_cnt_q <= FLASH_RELOAD;
            end else if (flash_cnt_q == 8'd0) begin
              state_q <= RUN;
            end else begin
              flash_cnt_q <= flash_cnt_q - 8'd1;
            end
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

  // Colour of the pixel being scanned; box overrides border overrides background.
  always_comb begin
    logic visible, in_box;
    visible = (next_x < H_LIM) && (next_y < V_LIM);
    in_box  = ({1'b0, next_x} >= box_x) && ({1'b0, next_x} < box_x + SIZE_W) &&
              ({1'b0, next_y} >= box_y) && ({1'b0, next_y} < box_y + SIZE_W);
    rgb_d = 24'h000000;
    if (visible) begin
      rgb_d = BG_COLOR;
`ifdef BORDER_EN
      if (next_x == 10'd0 || next_x == H_LIM - 10'd1 ||
          next_y == 10'd0 || next_y == V_LIM - 10'd1) begin
        rgb_d = BORDER_COLOR;
      end
`endif
      if (in_box) begin
        rgb_d = (state_q == FLASH) ? FLASH_COLOR : BOX_COLOR;
      end
    end
  end

  // Register the pixel colour (one cycle latency from the scan coordinates).
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign red        = rgb_q[23:16];
  assign green      = rgb_q[15:8];
  assign blue       = rgb_q[7:0];
  assign frame_tick = frame_tick_q;
  assign hit        = hit_q;

endmodule
